// File: rtl/taxi_fare_meter.sv
// Distance-based taxi fare meter.
// Counts 10 m odometer strobes into billing units and picks the tariff stage
// from the distance travelled. It accumulates a saturating fare for each trip
// under an IDLE / RUN / HOLD trip state machine. Every output is registered.
module taxi_fare_meter #(
   parameter int DW              = 32,
   parameter int PULSES_PER_UNIT = 50,
   parameter int INITIAL_PRICE   = 80,
   parameter int STAGE2_UNITS    = 6,
   parameter int STAGE3_UNITS    = 20,
   parameter int PRICE_STAGE1    = 0,
   parameter int PRICE_STAGE2    = 14,
   parameter int PRICE_STAGE3    = 20,
   parameter int PRICE_MAX       = 99999
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pulse_10m,
   input  logic          trip_start,
   input  logic          trip_end,
   output logic [DW-1:0] total_price,
   output logic [DW-1:0] distance_units,
   output logic [1:0]    stage,
   output logic          running,
   output logic          price_tick
);

   // One extra bit so that PULSES_PER_UNIT=1 still has a legal 1-bit counter.
   localparam int SCW = $clog2(PULSES_PER_UNIT) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [SCW-1:0] SUB_LAST  = SCW'(PULSES_PER_UNIT - 1);
   localparam logic [DW:0]    PMAX_W    = (DW+1)'(PRICE_MAX);
   localparam logic [DW-1:0]  INIT_P    = DW'(INITIAL_PRICE);
   localparam logic [DW-1:0]  S2_UNITS  = DW'(STAGE2_UNITS);
   localparam logic [DW-1:0]  S3_UNITS  = DW'(STAGE3_UNITS);

   logic [1:0]     state, state_nxt;
   logic [SCW-1:0] sub_cnt, sub_nxt;
   logic [DW-1:0]  price_nxt, dist_nxt;
   logic [1:0]     stage_nxt;
   logic           tick_nxt;

   logic           unit_done;
   logic [DW:0]    price_sum;
   logic [DW-1:0]  price_sat;
   logic [DW-1:0]  dist_inc;

   // Tariff stage implied by a completed-unit count.
   function automatic logic [1:0] stage_of(input logic [DW-1:0] units);
      if (units < S2_UNITS)      stage_of = 2'd1;
      else if (units < S3_UNITS) stage_of = 2'd2;
      else                       stage_of = 2'd3;
   endfunction

   // Per-unit increment for a given stage.
   function automatic logic [DW-1:0] unit_price(input logic [1:0] stg);
      case (stg)
         2'd1:    unit_price = DW'(PRICE_STAGE1);
         2'd2:    unit_price = DW'(PRICE_STAGE2);
         default: unit_price = DW'(PRICE_STAGE3);
      endcase
   endfunction

   // Unit-completion arithmetic. The unit is priced by the stage in force
   // before the increment. The sum carries one spare bit so that the
   // overflow clamps instead of wrapping.
   always_comb begin
      unit_done = (state == S_RUN) && pulse_10m && (sub_cnt == SUB_LAST);
      price_sum = {1'b0, total_price} + {1'b0, unit_price(stage_of(distance_units))};
      price_sat = (price_sum > PMAX_W) ? PMAX_W[DW-1:0] : price_sum[DW-1:0];
      dist_inc  = (&distance_units) ? distance_units : distance_units + 1'b1;
   end

   // Trip state machine and next-state datapath.
   always_comb begin
      state_nxt = state;
      sub_nxt   = sub_cnt;
      price_nxt = total_price;
      dist_nxt  = distance_units;
      tick_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (trip_start) begin
               state_nxt = S_RUN;
               price_nxt = INIT_P;
               dist_nxt  = '0;
               sub_nxt   = '0;
            end
         end
         S_RUN: begin
            // A pulse that arrives with trip_end is still counted before the freeze.
            if (pulse_10m) begin
               if (unit_done) begin
                  sub_nxt   = '0;
                  dist_nxt  = dist_inc;
                  price_nxt = price_sat;
                  tick_nxt  = 1'b1;
               end else begin
                  sub_nxt = sub_cnt + 1'b1;
               end
            end
            // trip_end beats a simultaneous trip_start, and trip_start alone is ignored.
            if (trip_end) state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (trip_start) begin
               state_nxt = S_RUN;
               price_nxt = INIT_P;
               dist_nxt  = '0;
               sub_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            price_nxt = '0;
            dist_nxt  = '0;
            sub_nxt   = '0;
         end
      endcase
      stage_nxt = (state_nxt == S_IDLE) ? 2'd0 : stage_of(dist_nxt);
   end

   // State and output registers. A reset discards any partial sub-count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         sub_cnt        <= '0;
         total_price    <= '0;
         distance_units <= '0;
         stage          <= 2'd0;
         running        <= 1'b0;
         price_tick     <= 1'b0;
      end else begin
         state          <= state_nxt;
         sub_cnt        <= sub_nxt;
         total_price    <= price_nxt;
         distance_units <= dist_nxt;
         stage          <= stage_nxt;
         running        <= (state_nxt == S_RUN);
         price_tick     <= tick_nxt;
      end
   end

endmodule
